// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES core arbiter: block width, FSM state encoding
// and the index-width helper used by every file that carries a requester index.
package aes_arb_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP,
    RECOVER
  } arb_state_e;

  // A single requester still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Requester-side and core-side signals of the AES core arbiter; the slave
// modport is the arbiter, the master modport is whatever drives it.
interface aes_core_arbiter_if #(
  parameter int NUM_REQ = 2
);

  localparam int IDX_W = aes_arb_pkg::idx_width(NUM_REQ);
  localparam int BW    = aes_arb_pkg::AES_BLOCK_W;

  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ-1:0][BW-1:0] req_data_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [NUM_REQ-1:0]         rsp_valid_o;
  logic [BW-1:0]              rsp_data_o;
  logic                       rsp_err_o;
  logic [BW-1:0]              core_data_o;
  logic                       core_ld_o;
  logic                       core_rst_o;
  logic                       core_done_i;
  logic [BW-1:0]              core_data_i;
  logic                       busy_o;
  logic [IDX_W-1:0]           owner_o;

  modport slave (
    input  req_valid_i, req_data_i, core_done_i, core_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           core_data_o, core_ld_o, core_rst_o, busy_o, owner_o
  );

  modport master (
    output req_valid_i, req_data_i, core_done_i, core_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           core_data_o, core_ld_o, core_rst_o, busy_o, owner_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last grant and
// wraps, returning both a one-hot grant and the winner's index.
module rr_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [idx_width(NUM_REQ)-1:0]      last_grant_i,
  output logic [NUM_REQ-1:0]                 grant_o,
  output logic [idx_width(NUM_REQ)-1:0]      idx_o
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core among NUM_REQ requesters: round-robin accept, one load
// strobe, wait for done with a hang timeout that resets the core and errors out.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              HCLK,
  input  logic              HRESET,
  aes_core_arbiter_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [AES_BLOCK_W-1:0] core_data_q, core_data_d;
  logic [AES_BLOCK_W-1:0] rsp_data_q, rsp_data_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic                   rsp_err;
  logic                   core_ld;
  logic                   core_rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i        (bus.req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .idx_o        (grant_idx)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      core_data_q  <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      core_data_q  <= core_data_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    core_data_d  = core_data_q;
    rsp_data_d   = rsp_data_q;
    err_d        = err_q;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_err      = 1'b0;
    core_ld      = 1'b0;
    core_rst     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid_i) begin
          req_ready   = grant;
          core_data_d = bus.req_data_i[grant_idx];
          owner_d     = grant_idx;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        core_ld = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done takes priority over the timeout on the last allowed cycle
        if (bus.core_done_i) begin
          rsp_data_d = bus.core_data_i;
          err_d      = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECOVER: begin
        core_rst = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          cnt_d      = '0;
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid    = NUM_REQ'(1) << owner_q;
        rsp_err      = err_q;
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The accept pulse is combinational from req_valid_i, so mask it during reset.
  assign bus.req_ready_o = HRESET ? '0 : req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.core_data_o = core_data_q;
  assign bus.core_ld_o   = core_ld;
  assign bus.core_rst_o  = core_rst;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.owner_o     = owner_q;

endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters sharing one AES core (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum WAIT cycles before the core is declared hung (>=4).
REQ-003 SHALL have ports: HCLK  in  1  sole clock, rising edge; all logic synchronous to it.
REQ-004 SHALL have ports: HRESET  in  1  reset, asynchronous assertion, active-high.
REQ-005 SHALL have ports: req_valid_i  in  NUM_REQ  per-requester block pending.
REQ-006 SHALL have ports: req_data_i  in  NUM_REQ x 128  per-requester plaintext block.
REQ-007 SHALL have ports: req_ready_o  out  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-008 SHALL have ports: rsp_valid_o  out  NUM_REQ  one-cycle completion pulse to the owner.
REQ-009 SHALL have ports: rsp_data_o  out  128  result, shared, valid while rsp_valid_o is non-zero; rsp_err_o  out  1  timeout flag, qualified by rsp_valid_o.
REQ-010 SHALL have ports: core_data_o  out  128  block to core; core_ld_o  out  1  load strobe; core_rst_o  out  1  core reset.
REQ-011 SHALL have ports: core_done_i  in  1  core completion; core_data_i  in  128  core result.
REQ-012 SHALL have ports: busy_o  out  1  state != IDLE; owner_o  out  clog2(NUM_REQ)  current or last owner index.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, WAIT, RESP, RECOVER.
REQ-014 IDLE: when any req_valid_i bit is set, SHALL grant round-robin starting at last_grant+1 (wrapping at NUM_REQ-1 to 0), latch req_data_i[winner] into core_data_o, pulse req_ready_o[winner] in that cycle, set owner_o, and go to LOAD.
REQ-015 IDLE with no request: SHALL remain in IDLE with all strobes low.
REQ-016 LOAD: SHALL drive core_ld_o=1 for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-017 core_done_i asserted in IDLE, LOAD or RESP SHALL be ignored.
REQ-018 WAIT: on core_done_i=1 SHALL capture core_data_i into rsp_data_o and go to RESP; otherwise SHALL increment the counter.
REQ-019 WAIT: when the counter reaches TIMEOUT_CYCLES-1 without done SHALL go to RECOVER; if done arrives in that same cycle, done SHALL win.
REQ-020 RESP: SHALL pulse rsp_valid_o[owner]=1 for one cycle with rsp_err_o=0, set last_grant=owner, and go to IDLE.
REQ-021 RECOVER: SHALL drive core_rst_o=1 for exactly 2 cycles, then pulse rsp_valid_o[owner] with rsp_err_o=1 and rsp_data_o=0, set last_grant=owner, and go to IDLE.
REQ-022 core_data_o SHALL be held stable from LOAD through the end of WAIT/RECOVER.
REQ-023 A requester that deasserts req_valid_i after its grant SHALL NOT affect the transaction in flight.
REQ-024 Latency: accept (cycle 0) -> core_ld_o (cycle 1) -> done at cycle d -> rsp_valid_o at cycle d+1.
REQ-025 At most one bit of req_ready_o and of rsp_valid_o SHALL be set in any cycle.

Reset
REQ-026 On HRESET=1, SHALL asynchronously force state=IDLE, counter=0, last_grant=NUM_REQ-1 (requester 0 wins first), owner_o=0.
REQ-027 During reset, all outputs SHALL be 0: req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o, core_data_o, core_ld_o, core_rst_o and busy_o.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no response pulse.

Structure
REQ-029 Package aes_arb_pkg SHALL hold AES_BLOCK_W=128 and the FSM state enum.
REQ-030 The round-robin grant logic SHALL be the sub-module rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant and index).

Verification
REQ-031 Single request: req_valid_i=01, data 0x00112233_44556677_8899AABB_CCDDEEFF, core done 10 cycles after ld, returning 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A -> rsp_valid_o=01, err=0, that data, at cycle 12 after accept.
REQ-032 Contention: req_valid_i=11 held for 3 transactions -> grants occur in the order 0,1,0.
REQ-033 Timeout: core_done_i never asserted -> core_rst_o high for 2 cycles after 64 WAIT cycles, then rsp_valid_o[owner]=1, err=1, data=0.
REQ-034 Done on the final timeout cycle (WAIT count 63) -> normal response with err=0 and no core_rst_o.
REQ-035 HRESET pulsed in WAIT -> all outputs 0 immediately, no rsp_valid_o, and the next grant goes to requester 0.
REQ-036 Spurious core_done_i in IDLE and LOAD -> no state change and no response.
